// File: rtl/qaoa_kernel_sdiv_68s_23s_49_seq_if.sv
// rtl/qaoa_kernel_sdiv_68s_23s_49_seq_if.sv - handshake/data bundle for the sequential signed divider
// Signals:
//   ce          clock enable for every register in the divider
//   start/ready operand request and accept-able indication
//   din0/din1   signed dividend / signed divisor
//   done        result-valid (high while the divider sits in DONE)
//   dout/rem    signed quotient / signed remainder
//   dbz         divide-by-zero flag for the current result
// Modports: master drives operands and ce, slave is the divider.
interface qaoa_kernel_sdiv_68s_23s_49_seq_if #(
  parameter int din0_WIDTH = 68,
  parameter int din1_WIDTH = 23,
  parameter int dout_WIDTH = 49
);
  logic                  ce;
  logic                  start;
  logic                  ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  done;
  logic [dout_WIDTH-1:0] dout;
  logic [din1_WIDTH-1:0] rem;
  logic                  dbz;

  modport master (
    output ce, start, din0, din1,
    input  ready, done, dout, rem, dbz
  );

  modport slave (
    input  ce, start, din0, din1,
    output ready, done, dout, rem, dbz
  );
endinterface

// File: rtl/qaoa_kernel_sdiv_68s_23s_49_seq.sv
// rtl/qaoa_kernel_sdiv_68s_23s_49_seq.sv - sequential restoring signed divider, truncating toward zero
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    slave side of the divider bundle (ce, start/ready, din0/din1, done, dout/rem/dbz)
// Operation: accept -> din0_WIDTH restoring steps on magnitudes -> sign fix -> DONE.
// The step counter terminates one cycle after the last step, which places the
// rise of done din0_WIDTH+2 enabled edges after the accept edge.
module qaoa_kernel_sdiv_68s_23s_49_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 68,
  parameter int din1_WIDTH = 23,
  parameter int dout_WIDTH = 49
) (
  input logic clk,
  input logic reset,
  qaoa_kernel_sdiv_68s_23s_49_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CNT_W = $clog2(din0_WIDTH + 1);
  localparam int RW    = din1_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(din0_WIDTH);

  wire [31:0] unused_id = ID;

  state_t state, state_nxt;

  logic [CNT_W-1:0]      cnt;
  logic [din0_WIDTH-1:0] quo;      // dividend magnitude shifts out, quotient bits shift in
  logic [din1_WIDTH-1:0] part;     // partial remainder
  logic [din1_WIDTH-1:0] div_mag;
  logic [din1_WIDTH-1:0] a_low;    // raw low dividend bits, returned as rem on divide-by-zero
  logic                  sign_a;
  logic                  sign_q;
  logic                  zero_div;

  logic [dout_WIDTH-1:0] dout_q;
  logic [din1_WIDTH-1:0] rem_q;
  logic                  dbz_q;

  logic                  ready_i;
  logic                  accept;
  logic [din0_WIDTH-1:0] a_mag;
  logic [din1_WIDTH-1:0] b_mag;
  logic [RW-1:0]         trial;
  logic                  ge;
  logic [din1_WIDTH-1:0] diff;
  logic [dout_WIDTH-1:0] dout_fix;
  logic [din1_WIDTH-1:0] rem_fix;

  assign ready_i   = (state == IDLE) || (state == DONE);
  assign accept    = bus.ce && bus.start && ready_i;
  assign bus.ready = ready_i;
  // A ce-low DONE cycle keeps done asserted because the state itself is frozen.
  assign bus.done  = (state == DONE);
  assign bus.dout  = dout_q;
  assign bus.rem   = rem_q;
  assign bus.dbz   = dbz_q;

  assign a_mag = bus.din0[din0_WIDTH-1] ? (din0_WIDTH'(0) - bus.din0) : bus.din0;
  assign b_mag = bus.din1[din1_WIDTH-1] ? (din1_WIDTH'(0) - bus.din1) : bus.din1;

  // Restoring step: the true difference is always below the divisor, so the
  // low din1_WIDTH bits of the subtraction are exact.
  assign trial = {part, quo[din0_WIDTH-1]};
  assign ge    = (trial >= {1'b0, div_mag});
  assign diff  = trial[din1_WIDTH-1:0] - div_mag;

  // Low bits of a negation depend only on low bits, so only the kept slice is negated.
  always_comb begin
    dout_fix = sign_q ? (dout_WIDTH'(0) - quo[dout_WIDTH-1:0]) : quo[dout_WIDTH-1:0];
    rem_fix  = sign_a ? (din1_WIDTH'(0) - part) : part;
    if (zero_div) begin
      dout_fix = '1;
      rem_fix  = a_low;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (bus.ce) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == LAST_CNT) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      quo      <= '0;
      part     <= '0;
      div_mag  <= '0;
      a_low    <= '0;
      sign_a   <= 1'b0;
      sign_q   <= 1'b0;
      zero_div <= 1'b0;
      dout_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else if (bus.ce) begin
      if (accept) begin
        cnt      <= '0;
        quo      <= a_mag;
        part     <= '0;
        div_mag  <= b_mag;
        a_low    <= bus.din0[din1_WIDTH-1:0];
        sign_a   <= bus.din0[din0_WIDTH-1];
        sign_q   <= bus.din0[din0_WIDTH-1] ^ bus.din1[din1_WIDTH-1];
        zero_div <= (bus.din1 == '0);
      end else if (state == CALC && cnt != LAST_CNT) begin
        quo  <= {quo[din0_WIDTH-2:0], ge};
        part <= ge ? diff : trial[din1_WIDTH-1:0];
        cnt  <= cnt + CNT_W'(1);
      end
      if (state == FIX) begin
        dout_q <= dout_fix;
        rem_q  <= rem_fix;
        dbz_q  <= zero_div;
      end
    end
  end

endmodule

// File: tb/tb_qaoa_kernel_sdiv_68s_23s_49_seq.sv
// tb/tb_qaoa_kernel_sdiv_68s_23s_49_seq.sv - self-checking bench for the sequential signed divider
module tb_qaoa_kernel_sdiv_68s_23s_49_seq;

  logic clk = 1'b0;
  logic reset;

  qaoa_kernel_sdiv_68s_23s_49_seq_if bus ();

  qaoa_kernel_sdiv_68s_23s_49_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference result packed as {dbz, rem[22:0], dout[48:0]} using wide signed arithmetic.
  function automatic logic [72:0] model(input logic signed [67:0] a, input logic signed [22:0] b);
    logic signed [71:0] aw, bw, q, r;
    if (b == 0) return {1'b1, a[22:0], {49{1'b1}}};
    aw = a;
    bw = b;
    q = aw / bw;
    r = aw % bw;
    return {1'b0, r[22:0], q[48:0]};
  endfunction

  // Transaction-level model: an accepted operation completes 70 enabled edges later.
  bit            pending  = 1'b0;
  bit            exp_done = 1'b0;
  bit            rdy;
  int            left     = 0;
  logic [72:0]   cur_exp  = '0;
  logic [72:0]   expq[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  = 1'b0;
      exp_done = 1'b0;
      left     = 0;
      cur_exp  = '0;
      expq.delete();
    end else if (bus.ce) begin
      rdy      = !pending;
      exp_done = 1'b0;
      if (pending) begin
        left--;
        if (left == 0) begin
          pending  = 1'b0;
          exp_done = 1'b1;
          cur_exp  = expq.pop_front();
        end
      end
      if (bus.start && rdy) begin
        pending = 1'b1;
        left    = 70;
        expq.push_back(model(bus.din0, bus.din1));
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", 73'(bus.ready), 73'(!pending));
    chk("done", 73'(bus.done), 73'(exp_done));
    chk("held result", {bus.dbz, bus.rem, bus.dout}, cur_exp);
  end

  task automatic op(input logic [67:0] a, input logic [22:0] b, input logic [48:0] q,
                    input logic [22:0] r, input logic z, input bit toggle, input int lat,
                    input string nm);
    int n;
    bit seen;
    @(negedge clk);
    bus.ce    = 1'b1;
    bus.din0  = a;
    bus.din1  = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      if (toggle) bus.ce = ~bus.ce;
      if (toggle && n == 20) begin
        bus.start = 1'b1;
        bus.din0  = 68'd5;
        bus.din1  = 23'd1;
      end
      if (toggle && n == 22) bus.start = 1'b0;
      @(posedge clk);
      n++;
      #1;
      if (bus.done) seen = 1'b1;
    end
    bus.ce = 1'b1;
    chk({nm, " latency"}, 73'(n), 73'(lat));
    chk({nm, " result"}, {bus.dbz, bus.rem, bus.dout}, {z, r, q});
  endtask

  logic [67:0] min_neg;
  logic [67:0] two_40;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.ce    = 1'b1;
    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;
    reset     = 1'b1;
    min_neg   = {1'b1, 67'b0};
    two_40    = 68'd1 << 40;
    #1 reset  = 1'b0;
    #2;
    chk("reset ready", 73'(bus.ready), 73'(1));
    chk("reset done", 73'(bus.done), 73'(0));
    chk("reset outputs", {bus.dbz, bus.rem, bus.dout}, 73'(0));

    chk("model 100/7", model(68'd100, 23'd7), {1'b0, 23'd2, 49'd14});
    chk("model -100/7", model(68'(-100), 23'd7), {1'b0, 23'(-2), 49'(-14)});
    chk("model 12345/0", model(68'd12345, 23'd0), {1'b1, 23'd12345, {49{1'b1}}});
    chk("model min/-1", model(min_neg, 23'(-1)), {1'b0, 23'd0, 49'd0});
    chk("model 2^40/1", model(two_40, 23'd1), {1'b0, 23'd0, 49'h100_0000_0000});

    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    op(68'd100, 23'd7, 49'd14, 23'd2, 1'b0, 1'b0, 70, "100/7");
    repeat (2) @(negedge clk);
    op(68'(-100), 23'd7, 49'(-14), 23'(-2), 1'b0, 1'b0, 70, "-100/7");
    repeat (2) @(negedge clk);
    op(68'd100, 23'(-7), 49'(-14), 23'd2, 1'b0, 1'b0, 70, "100/-7");
    repeat (2) @(negedge clk);
    op(68'(-100), 23'(-7), 49'd14, 23'(-2), 1'b0, 1'b0, 70, "-100/-7");
    repeat (2) @(negedge clk);
    op(68'd12345, 23'd0, {49{1'b1}}, 23'd12345, 1'b1, 1'b0, 70, "12345/0");
    repeat (2) @(negedge clk);
    op(min_neg, 23'(-1), 49'd0, 23'd0, 1'b0, 1'b0, 70, "min/-1");
    repeat (2) @(negedge clk);
    op(two_40, 23'd1, 49'h100_0000_0000, 23'd0, 1'b0, 1'b0, 70, "2^40/1");
    repeat (2) @(negedge clk);
    op(68'd100, 23'd7, 49'd14, 23'd2, 1'b0, 1'b1, 140, "ce toggle 100/7");

    // Consecutive calls: each new start lands in the previous DONE cycle.
    op(68'(-100), 23'd7, 49'(-14), 23'(-2), 1'b0, 1'b0, 70, "b2b -100/7");
    op(68'd1000, 23'(-3), 49'(-333), 23'd1, 1'b0, 1'b0, 70, "b2b 1000/-3");

    @(negedge clk);
    bus.din0  = 68'd999;
    bus.din1  = 23'd10;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort ready", 73'(bus.ready), 73'(1));
    chk("abort done", 73'(bus.done), 73'(0));
    chk("abort outputs", {bus.dbz, bus.rem, bus.dout}, 73'(0));
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    op(68'd100, 23'd7, 49'd14, 23'd2, 1'b0, 1'b0, 70, "after reset 100/7");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
